// File: rtl/keyboard_spi_frame_tx.sv
// SPI master sending a one-time sync word, then 128-bit note frames (3 periods + control) MSB first.
// Latency: first bit 1 cycle after an accepted start; start is ignored while busy or finishing (no queue).
module keyboard_spi_frame_tx #(
   parameter int          CLK_DIV   = 8,
   parameter logic [31:0] SYNC_WORD = 32'h0000_FFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] prd1,
   input  logic [31:0] prd2,
   input  logic [31:0] prd3,
   input  logic [1:0]  waveform,
   input  logic [1:0]  notes,
   output logic        sck,
   output logic        sdo,
   output logic        busy,
   output logic        done
);

   localparam int            CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

   typedef enum logic [1:0] {IDLE, SYNC, FRAME, FINISH} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  half_q, half_d;
   logic [6:0]     bit_q, bit_d;
   logic [127:0]   shadow_q, shadow_d;
   logic           synced_q, synced_d;
   logic           sck_q, sck_d;
   logic           sdo_q, sdo_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;

   logic [127:0]   frame_word;
   logic [6:0]     bit_dec;

   assign frame_word = {prd1, prd2, prd3, 28'b0, notes, waveform};
   assign bit_dec    = bit_q - 7'd1;

   always_comb begin
      state_d  = state_q;
      half_d   = half_q;
      bit_d    = bit_q;
      shadow_d = shadow_q;
      synced_d = synced_q;
      sck_d    = sck_q;
      sdo_d    = sdo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               shadow_d = frame_word;
               busy_d   = 1'b1;
               sck_d    = 1'b0;
               half_d   = '0;
               if (synced_q) begin
                  state_d = FRAME;
                  bit_d   = 7'd127;
                  sdo_d   = frame_word[127];
               end else begin
                  state_d = SYNC;
                  bit_d   = 7'd31;
                  sdo_d   = SYNC_WORD[31];
               end
            end
         end
         SYNC, FRAME: begin
            if (half_q != HALF_LAST) begin
               half_d = half_q + CW'(1);
            end else begin
               half_d = '0;
               if (!sck_q) begin
                  sck_d = 1'b1;
               end else begin
                  // End of a bit: sck falls and sdo moves on in the same cycle.
                  sck_d = 1'b0;
                  if (bit_q != 7'd0) begin
                     bit_d = bit_dec;
                     sdo_d = (state_q == SYNC) ? SYNC_WORD[bit_dec[4:0]] : shadow_q[bit_dec];
                  end else if (state_q == SYNC) begin
                     synced_d = 1'b1;
                     state_d  = FRAME;
                     bit_d    = 7'd127;
                     sdo_d    = shadow_q[127];
                  end else begin
                     state_d = FINISH;
                     sdo_d   = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         half_q   <= '0;
         bit_q    <= '0;
         shadow_q <= '0;
         synced_q <= 1'b0;
         sck_q    <= 1'b0;
         sdo_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
         synced_q <= synced_d;
         sck_q    <= sck_d;
         sdo_q    <= sdo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sck  = sck_q;
   assign sdo  = sdo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_keyboard_spi_frame_tx.sv
// Directed bench for keyboard_spi_frame_tx with a receiver shift-register model on sck rises.
module tb_keyboard_spi_frame_tx;

   localparam int CLK_DIV = 8;
   localparam int BIT_CYC = 2 * CLK_DIV;
   localparam logic [127:0] FRAME_BITS = {32'h00012345, 32'h0000ABCD, 32'h00000FFF, 32'h0000000E};
   localparam logic [159:0] FULL_BITS  = {32'h0000FFFF, FRAME_BITS};
   localparam logic [159:0] ONLY_FRAME = {32'h0, FRAME_BITS};

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] prd1, prd2, prd3;
   logic [1:0]  waveform, notes;
   logic        sck, sdo, busy, done;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   keyboard_spi_frame_tx #(
      .CLK_DIV   (CLK_DIV),
      .SYNC_WORD (32'h0000_FFFF)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .prd1     (prd1),
      .prd2     (prd2),
      .prd3     (prd3),
      .waveform (waveform),
      .notes    (notes),
      .sck      (sck),
      .sdo      (sdo),
      .busy     (busy),
      .done     (done)
   );

   // Receiver model: shifts sdo on each sck rise, counts done pulses and sdo changes while sck is high.
   logic         prev_sck = 1'b0;
   logic         prev_sdo = 1'b0;
   int           rise_cnt = 0;
   int           done_cnt = 0;
   int           hi_chg   = 0;
   logic [159:0] rx_sh    = '0;

   always @(negedge clk) begin
      prev_sck <= sck;
      prev_sdo <= sdo;
      if (sck === 1'b1 && prev_sck === 1'b0) begin
         rise_cnt <= rise_cnt + 1;
         rx_sh    <= {rx_sh[158:0], sdo};
      end
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (sck === 1'b1 && prev_sck === 1'b1 && sdo !== prev_sdo) hi_chg <= hi_chg + 1;
   end

   task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Caller sits on the negedge sample of cycle cyc_in; returns on the done cycle or at the bound.
   task automatic wait_done(input string tag, input int cyc_in, input int max, output int cyc);
      cyc = cyc_in;
      while (done !== 1'b1 && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_done_seen"}, done, 1);
   endtask

   task automatic run_frame(input string tag, input int nbits, input logic [159:0] exp_bits,
                            input bit measure, input bit disturb);
      int base_r, base_d, cyc, hi, lo;
      base_r = rise_cnt;
      base_d = done_cnt;
      pulse_start();
      @(negedge clk);
      cyc = 1;
      if (measure) begin
         check({tag, "_lat_busy"}, busy, 1);
         check({tag, "_lat_sdo"}, sdo, 0);
         check({tag, "_lat_sck"}, sck, 0);
         while (sck !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         check({tag, "_first_rise_cyc"}, cyc, CLK_DIV + 1);
         hi = 0;
         while (sck === 1'b1 && hi < 100) begin
            hi++;
            @(negedge clk);
         end
         check({tag, "_sck_high_len"}, hi, CLK_DIV);
         lo = 0;
         while (sck === 1'b0 && lo < 100) begin
            lo++;
            @(negedge clk);
         end
         check({tag, "_sck_low_len"}, lo, CLK_DIV);
         cyc += hi + lo;
      end
      if (disturb) begin
         repeat (300) begin
            @(negedge clk);
            cyc++;
         end
         prd1  = 32'hDEADBEEF;
         start = 1'b1;
         @(negedge clk);
         cyc++;
         start = 1'b0;
      end
      wait_done(tag, cyc, 4000, cyc);
      check({tag, "_len"}, cyc, nbits * BIT_CYC + 1);
      check({tag, "_finish_busy"}, busy, 0);
      check({tag, "_finish_sck_sdo"}, {sck, sdo}, 2'b00);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 0);
      check({tag, "_rises"}, rise_cnt - base_r, nbits);
      check({tag, "_dones"}, done_cnt - base_d, 1);
      check({tag, "_bits"}, (nbits == 160) ? rx_sh : {32'h0, rx_sh[127:0]}, exp_bits);
      check({tag, "_ctrl_word"}, rx_sh[31:0], 32'h0000000E);
   endtask

   initial begin
      int base_r, base_d, cyc;
      reset    = 1'b1;
      start    = 1'b0;
      prd1     = 32'h0001_2345;
      prd2     = 32'h0000_ABCD;
      prd3     = 32'h0000_0FFF;
      waveform = 2'd2;
      notes    = 2'd3;
      repeat (3) @(negedge clk);
      check("rst_sck", sck, 0);
      check("rst_sdo", sdo, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      // First frame after reset carries the sync word; bit timing measured here.
      run_frame("f1", 160, FULL_BITS, 1'b1, 1'b0);

      // Already synced: frame only.
      run_frame("f2", 128, ONLY_FRAME, 1'b0, 1'b0);

      // Mid-frame start and prd1 change must not disturb the frame in flight.
      run_frame("f3_disturb", 128, ONLY_FRAME, 1'b0, 1'b1);
      base_d = done_cnt;
      repeat (20) @(negedge clk);
      check("f3_no_queued_frame", busy, 0);
      check("f3_no_extra_done", done_cnt - base_d, 0);
      prd1 = 32'h0001_2345;

      // Reset during FRAME bit 60 (68th rise), high phase.
      base_r = rise_cnt;
      base_d = done_cnt;
      pulse_start();
      @(negedge clk);
      cyc = 1;
      while (rise_cnt - base_r < 68 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("abort_bit60_reached", rise_cnt - base_r, 68);
      check("abort_mid_bit", {sck, busy}, 2'b11);
      reset = 1'b1;
      @(negedge clk);
      check("abort_sck", sck, 0);
      check("abort_sdo", sdo, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_no_done_pulse", done_cnt - base_d, 0);
      run_frame("f_resync", 160, FULL_BITS, 1'b0, 1'b0);

      // start held high: three back-to-back frames with a two-cycle gap.
      base_r = rise_cnt;
      base_d = done_cnt;
      start  = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      for (int f = 0; f < 3; f++) begin
         wait_done("b2b", 1, 2200, cyc);
         check("b2b_len", cyc, 128 * BIT_CYC + 1);
         @(negedge clk);
         check("b2b_idle_cycle", {busy, sck}, 2'b00);
         @(negedge clk);
         check("b2b_next_first_bit", busy, (f < 2) ? 1 : 0);
         if (f == 1) start = 1'b0;
      end
      @(negedge clk);
      check("b2b_rises", rise_cnt - base_r, 3 * 128);
      check("b2b_dones", done_cnt - base_d, 3);
      check("b2b_last_bits", {32'h0, rx_sh[127:0]}, ONLY_FRAME);

      check("sdo_stable_while_sck_high", hi_chg, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
